// File: rtl/wts_mix_pkg.sv
// Shared constants and signed sample/product/accumulator types for the 5-channel tone mixer.
package wts_mix_pkg;

  localparam int unsigned NUM_CH  = 5;
  localparam int unsigned LAST_CH = 4;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned SMP_W   = 8;
  localparam int unsigned PROD_W  = 12;
  localparam int unsigned ACC_W   = 15;
  localparam int unsigned PEAK_W  = 8;

  // Slots IDLE_FIRST..7 carry no channel data
  localparam logic [CH_W-1:0] IDLE_FIRST = CH_W'(5);

  typedef logic signed [SMP_W-1:0]  sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/wts_channel_mixer_5ch_if.sv
// Slot input, mixed output and peak-meter readback signals of the 5-channel mixer.
interface wts_channel_mixer_5ch_if
  import wts_mix_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned VOL_W    = 4,
  parameter int unsigned OUT_W    = 12
);

  logic [CH_W-1:0]            active;
  logic signed [SAMPLE_W-1:0] sample;
  logic [VOL_W-1:0]           reg_volume;
  logic                       reg_enable;
  logic signed [OUT_W-1:0]    mix_out;
  logic                       mix_valid;
  logic [CH_W-1:0]            peak_sel;
  logic                       peak_clear;
  logic [PEAK_W-1:0]          peak_level;

  modport master (
    output active, sample, reg_volume, reg_enable, peak_sel, peak_clear,
    input  mix_out, mix_valid, peak_level
  );

  modport slave (
    input  active, sample, reg_volume, reg_enable, peak_sel, peak_clear,
    output mix_out, mix_valid, peak_level
  );

endinterface

// File: rtl/wts_volume_scaler.sv
// Stage 1: registered signed sample x unsigned volume product, gated by key-on; idle slots give a bubble.
module wts_volume_scaler
  import wts_mix_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned VOL_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CH_W-1:0]            active,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic [VOL_W-1:0]           volume,
  input  logic                       enable,
  output prod_t                      p1,
  output logic [CH_W-1:0]            p1_ch,
  output logic                       p1_valid
);

  prod_t sample_ext;
  prod_t volume_ext;
  prod_t prod;
  logic  slot_live;

  // Volume is zero-extended so the multiply stays signed without flipping its sign
  always_comb begin
    sample_ext = prod_t'(sample);
    volume_ext = prod_t'({1'b0, volume});
    prod       = sample_ext * volume_ext;
    slot_live  = (active < IDLE_FIRST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1       <= '0;
      p1_ch    <= '0;
      p1_valid <= 1'b0;
    end else begin
      p1_valid <= slot_live;
      if (slot_live) begin
        p1    <= enable ? prod : '0;
        p1_ch <= active;
      end
    end
  end

endmodule

// File: rtl/wts_channel_mixer_5ch.sv
// Volume-scales and sums the 5 time-multiplexed tone slots into one sample per frame, with per-channel peak meters.
// Optional build macro WTS_MIX_SATURATE_EN: output = clip(sum >>> 2) instead of sum >>> 3.
module wts_channel_mixer_5ch
  import wts_mix_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned VOL_W    = 4,
  parameter int unsigned OUT_W    = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  wts_channel_mixer_5ch_if.slave bus
);

  prod_t                   p1;
  logic [CH_W-1:0]         p1_ch;
  logic                    p1_valid;
  logic                    p1_last;
  acc_t                    acc;
  acc_t                    acc_sum;
  logic signed [OUT_W-1:0] mix_f;
  logic [PROD_W-1:0]       p1_mag;
  logic [PEAK_W-1:0]       m;
  logic [PEAK_W-1:0]       peak [NUM_CH];

  wts_volume_scaler #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W)
  ) u_scaler (
    .clk      (clk),
    .reset    (reset),
    .active   (bus.active),
    .sample   (bus.sample),
    .volume   (bus.reg_volume),
    .enable   (bus.reg_enable),
    .p1       (p1),
    .p1_ch    (p1_ch),
    .p1_valid (p1_valid)
  );

  // Channel 0 restarts the frame sum; every other slot accumulates
  always_comb begin
    p1_last = (p1_ch == CH_W'(LAST_CH));
    acc_sum = (p1_ch == '0) ? ACC_W'(p1) : acc + ACC_W'(p1);
    p1_mag  = p1[PROD_W-1] ? PROD_W'(-p1) : PROD_W'(p1);
    m       = PEAK_W'(p1_mag >> 3);
  end

`ifdef WTS_MIX_SATURATE_EN
  localparam acc_t SAT_HI = acc_t'((2 ** (int'(OUT_W) - 1)) - 1);
  localparam acc_t SAT_LO = acc_t'(-(2 ** (int'(OUT_W) - 1)));
  acc_t acc_shift;

  always_comb begin
    acc_shift = acc_sum >>> 2;
    if (acc_shift > SAT_HI)      mix_f = OUT_W'(SAT_HI);
    else if (acc_shift < SAT_LO) mix_f = OUT_W'(SAT_LO);
    else                         mix_f = OUT_W'(acc_shift);
  end
`else
  always_comb begin
    mix_f = OUT_W'(acc_sum >>> 3);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      bus.mix_out   <= '0;
      bus.mix_valid <= 1'b0;
    end else begin
      bus.mix_valid <= p1_valid && p1_last;
      if (p1_valid) begin
        acc <= acc_sum;
        if (p1_last) bus.mix_out <= mix_f;
      end
    end
  end

  // A clear on the same edge as an update of that channel leaves the new level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) peak[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (p1_valid && (p1_ch == CH_W'(i))) begin
          if (bus.peak_clear && (bus.peak_sel == CH_W'(i))) peak[i] <= m;
          else if (m > peak[i])                              peak[i] <= m;
        end else if (bus.peak_clear && (bus.peak_sel == CH_W'(i))) begin
          peak[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    bus.peak_level = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (bus.peak_sel == CH_W'(i)) bus.peak_level = peak[i];
    end
  end

endmodule

// File: tb/tb_wts_channel_mixer_5ch.sv
// Randomized scoreboard bench for wts_channel_mixer_5ch; reference model works on plain integers per slot.
module tb_wts_channel_mixer_5ch;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wts_channel_mixer_5ch_if bus ();

  wts_channel_mixer_5ch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_m = 0;
  int   peak_m [5];
  int   pend_valid = 0;
  int   pend_ch = 0;
  int   pend_m = 0;
  int   since0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int floor_div(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int mix_ref(int s);
`ifdef WTS_MIX_SATURATE_EN
    int q = floor_div(s, 4);
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return q;
`else
    return floor_div(s, 8);
`endif
  endfunction

  task automatic check(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // One slot cycle; the model applies the coming edge: clear first, then the previous slot's peak
  task automatic drive(int ch, int s, int v, bit en, bit clr = 1'b0, int csel = 0);
    int p;
    exp_t e;
    bus.active     = 3'(ch);
    bus.sample     = 8'(s);
    bus.reg_volume = 4'(v);
    bus.reg_enable = en;
    bus.peak_clear = clr;
    bus.peak_sel   = 3'(csel);
    if (clr && csel < 5) peak_m[csel] = 0;
    if (pend_valid != 0 && pend_m > peak_m[pend_ch]) peak_m[pend_ch] = pend_m;
    pend_valid = 0;
    if (ch < 5) begin
      p = en ? s * v : 0;
      acc_m = (ch == 0) ? p : acc_m + p;
      pend_valid = 1;
      pend_ch = ch;
      pend_m = ((p < 0) ? -p : p) / 8;
      if (ch == 4) begin
        e.val = mix_ref(acc_m);
        e.due = cyc + 2;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit rnd_clr = 1'b0);
    for (int k = 0; k < n; k++) begin
      bit c = rnd_clr && ($urandom_range(0, 3) == 0);
      drive(5 + int'($urandom_range(0, 2)), int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 15)), 1'b1, c, int'($urandom_range(0, 7)));
    end
  endtask

  task automatic check_peak(int sel);
    bus.peak_clear = 1'b0;
    bus.peak_sel   = 3'(sel);
    #1;
    check($sformatf("peak_level[%0d]", sel), int'(bus.peak_level), (sel < 5) ? peak_m[sel] : 0);
  endtask

  task automatic check_all_peaks();
    for (int s = 0; s < 8; s++) check_peak(s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend_valid = 0;
    acc_m = 0;
    for (int i = 0; i < 5; i++) peak_m[i] = 0;
    @(posedge clk);
    #1;
    check("reset_mix_out", int'(bus.mix_out), 0);
    check("reset_mix_valid", int'(bus.mix_valid), 0);
    check_all_peaks();
    reset = 1'b0;
  endtask

  task automatic rand_frame();
    for (int ch = 0; ch < 5; ch++) begin
      if ($urandom_range(0, 2) == 0) idle(1, 1'b1);
      drive(ch, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0);
    end
  endtask

  // Scoreboard monitor: every due entry must see mix_valid with the model value; no pulse otherwise
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          check("mix_valid_pulse", int'(bus.mix_valid), 1);
          check("mix_out", int'(bus.mix_out), e.val);
        end else if (bus.mix_valid) begin
          check("mix_valid_extra", int'(bus.mix_valid), 0);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) peak_m[i] = 0;
    reset          = 1'b1;
    bus.active     = 3'd7;
    bus.sample     = '0;
    bus.reg_volume = '0;
    bus.reg_enable = 1'b0;
    bus.peak_clear = 1'b0;
    bus.peak_sel   = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check("init_mix_out", int'(bus.mix_out), 0);
    check("init_mix_valid", int'(bus.mix_valid), 0);
    check_all_peaks();
    reset = 1'b0;

    // Full-scale positive and negative frames
    for (int ch = 0; ch < 5; ch++) drive(ch, 127, 15, 1'b1);
    idle(3);
    for (int ch = 0; ch < 5; ch++) drive(ch, -128, 15, 1'b1);
    idle(3);

    // Small values, channel C keyed off, idle slots interleaved
    drive(0, 10, 1, 1'b1);
    drive(6, 99, 15, 1'b1);
    drive(1, 10, 1, 1'b1);
    drive(5, -77, 9, 1'b1);
    drive(2, 10, 1, 1'b0);
    drive(7, 55, 3, 1'b1);
    drive(3, 10, 1, 1'b1);
    drive(4, 10, 1, 1'b1);
    idle(3);

    // Channel B peak: set, hold against smaller, clear coinciding with update
    drive(1, -100, 15, 1'b1);
    idle(2);
    check_peak(1);
    drive(1, 5, 15, 1'b1);
    idle(2);
    check_peak(1);
    drive(1, 5, 15, 1'b1);
    drive(7, 0, 0, 1'b0, 1'b1, 1);
    idle(1);
    check_peak(1);
    drive(7, 0, 0, 1'b0, 1'b1, 6);
    check_all_peaks();

    // Reset in the middle of a frame, then a clean frame
    drive(0, 50, 3, 1'b1);
    drive(1, -60, 7, 1'b1);
    drive(2, 33, 12, 1'b1);
    do_reset();
    rand_frame();
    idle(3);
    check_all_peaks();

    // Randomized ordered frames with random peak clears in idle slots
    for (int f = 0; f < 30; f++) begin
      rand_frame();
      if (f % 10 == 9) begin
        idle(2);
        check_all_peaks();
      end
    end

    // Random slot order, at most five products summed before a channel-0 restart
    since0 = 5;
    for (int k = 0; k < 200; k++) begin
      int ch = int'($urandom_range(0, 7));
      if (ch < 5 && ch != 0 && since0 >= 4) ch = 0;
      if (ch == 0) since0 = 0;
      else if (ch < 5) since0++;
      drive(ch, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)));
    end
    idle(4);
    check_all_peaks();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
